// File: rtl/palette_lookup.sv
// -----------------------------------------------------------------------------
// palette_lookup
//
// Read engine for one GBA palette inside the palette RAM. Pixel requests are
// accepted over a valid/ready handshake. Each accepted request is registered
// in stage S1, which drives the RAM read address. The returned BGR555 entry is
// expanded to RGB888 and pushed, in order, into a small output FIFO.
//
// Handshake rule (both sides): a transfer happens at a rising clk edge where
// valid && ready are both 1. Valid never waits on ready. On the request side,
// pix_ready depends only on registered state and rst. Nothing combinational
// runs from pix_valid or out_ready into pix_ready.
//
// Parameters
//   BASE_WORD   word offset of this palette inside the RAM (BG 0, OBJ 128)
//   FIFO_DEPTH  output FIFO entries (>= 3 for one pixel per clock)
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   pix_valid/ready   request handshake
//   pix_index         raw palette index from tile data
//   pix_8bpp          1 = 256-colour, 0 = 16-colour (uses pix_bank)
//   pix_bank          palette bank for 16-colour mode
//   pix_tag           opaque tag returned with the colour
//   ram_addr          14-bit word address to the palette RAM read port
//   ram_rdata         32-bit read data for ram_addr (same cycle)
//   out_valid/ready   colour handshake toward the compositor
//   out_rgb           {R8,G8,B8}
//   out_transparent   pixel is transparent
//   out_tag           pix_tag of this pixel
//   dbg_s1_valid      S1 occupancy, for observation
//   dbg_fifo_count    FIFO fill level, for observation
// -----------------------------------------------------------------------------
module palette_lookup #(
    parameter int BASE_WORD  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [7:0]  pix_index,
    input  logic        pix_8bpp,
    input  logic [3:0]  pix_bank,
    input  logic [7:0]  pix_tag,
    output logic [13:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic        out_transparent,
    output logic [7:0]  out_tag,
    output logic        dbg_s1_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] dbg_fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = 33;  // {rgb[23:0], transparent, tag[7:0]}

    localparam logic [13:0]   BASE_ADDR = 14'(BASE_WORD);
    localparam logic [CW:0]   DEPTH_C   = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    // ---------------- request decode ----------------
    logic [7:0]  eff;
    logic        req_transparent;
    logic [13:0] req_addr;
    logic        accept;

    always_comb begin
        eff             = pix_8bpp ? pix_index : {pix_bank, pix_index[3:0]};
        req_transparent = pix_8bpp ? (pix_index == 8'd0) : (pix_index[3:0] == 4'd0);
        req_addr        = BASE_ADDR + {7'd0, eff[7:1]};  // wraps modulo 2^14
    end

    // ---------------- stage S1 ----------------
    logic        s1_valid;
    logic [13:0] s1_addr;
    logic        s1_hi;
    logic        s1_transparent;
    logic [7:0]  s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid       <= 1'b0;
            s1_addr        <= BASE_ADDR;
            s1_hi          <= 1'b0;
            s1_transparent <= 1'b0;
            s1_tag         <= 8'd0;
        end else begin
            s1_valid <= accept;
            // The address register only loads on acceptance, so ram_addr
            // keeps its last value while S1 is empty.
            if (accept) begin
                s1_addr        <= req_addr;
                s1_hi          <= eff[0];
                s1_transparent <= req_transparent;
                s1_tag         <= pix_tag;
            end
        end
    end

    assign ram_addr = s1_addr;

    // ---------------- colour expansion ----------------
    logic [14:0] entry;
    logic [4:0]  r5, g5, b5;
    logic [23:0] s1_rgb;
    logic        unused_entry_msb;

    always_comb begin
        entry  = s1_hi ? ram_rdata[30:16] : ram_rdata[14:0];
        r5     = entry[4:0];
        g5     = entry[9:5];
        b5     = entry[14:10];
        // Replicating the top bits makes 0 map to 0x00 and 31 map to 0xFF.
        s1_rgb = {r5, r5[4:2], g5, g5[4:2], b5, b5[4:2]};
    end

    // Bit 15 of each BGR555 entry carries no colour information.
    assign unused_entry_msb = ram_rdata[31] ^ ram_rdata[15];

    // ---------------- output FIFO ----------------
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] last_entry;
    logic [EW-1:0] head;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // Space is reserved at acceptance: an S1 entry always has a FIFO slot.
    assign push      = s1_valid;
    assign pop       = (count != '0) && out_ready;
    assign occupancy = {1'b0, count} + (CW+1)'(s1_valid);
    assign pix_ready = !rst && (occupancy < DEPTH_C);
    assign accept    = pix_valid && pix_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s1_rgb, s1_transparent, s1_tag};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_entry <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr     <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
                // Remember what was shown, so the outputs hold once empty.
                last_entry <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head            = (count != '0) ? mem[rd_ptr] : last_entry;
    assign out_valid       = (count != '0);
    assign out_rgb         = head[32:9];
    assign out_transparent = head[8];
    assign out_tag         = head[7:0];

    assign dbg_s1_valid   = s1_valid;
    assign dbg_fifo_count = count;

endmodule
